// File: rtl/snd_mix4.sv
// snd_mix4 - four-channel signed audio mixer.
//
// Each channel is sign-extended to the widest channel width, scaled by an
// unsigned 4.4 gain (8'h10 = unity), the four products are summed, the sum
// is shifted right by 4 (floor) and saturated to wout bits. Three-stage
// pipeline advancing on cen; synchronous active-high reset.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active high (overrides cen)
//   cen          clock enable, pipeline advances only when high
//   ch0..ch3     signed samples, widths w0..w3
//   gain0..gain3 unsigned 4.4 gains
//   mixed        signed saturated mix, wout bits
//   clip         (only with SND_MIX4_CLIP_EN) high for a saturated sample
//
// Optional feature macro: SND_MIX4_CLIP_EN adds the clip output.

module snd_mix4 #(
  parameter int w0   = 16,
  parameter int w1   = 16,
  parameter int w2   = 16,
  parameter int w3   = 16,
  parameter int wout = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [w0-1:0]   ch0,
  input  logic [w1-1:0]   ch1,
  input  logic [w2-1:0]   ch2,
  input  logic [w3-1:0]   ch3,
  input  logic [7:0]      gain0,
  input  logic [7:0]      gain1,
  input  logic [7:0]      gain2,
  input  logic [7:0]      gain3,
  output logic [wout-1:0] mixed
`ifdef SND_MIX4_CLIP_EN
  ,
  output logic            clip
`endif
);

  localparam int wm01 = (w0 > w1) ? w0 : w1;
  localparam int wm23 = (w2 > w3) ? w2 : w3;
  localparam int wm   = (wm01 > wm23) ? wm01 : wm23;
  localparam int wp   = wm + 9;
  localparam int wsum = wm + 11;
  // Compare width: wide enough for both the shifted sum and the output
  // limits, plus one bit so the limits are representable as signed values.
  localparam int ws   = (((wm + 7) > wout) ? (wm + 7) : wout) + 1;

  localparam logic signed [ws-1:0] sat_hi = {{(ws-wout+1){1'b0}}, {(wout-1){1'b1}}};
  localparam logic signed [ws-1:0] sat_lo = {{(ws-wout+1){1'b1}}, {(wout-1){1'b0}}};

  logic signed [wm-1:0]   x0, x1, x2, x3;
  logic signed [wp-1:0]   p0_r, p1_r, p2_r, p3_r;
  logic signed [wsum-1:0] sum_r;
  logic signed [ws-1:0]   s_ext;
  logic [wout-1:0]        mixed_nxt;
`ifdef SND_MIX4_CLIP_EN
  logic                   clip_nxt;
`endif

  assign x0 = wm'(signed'(ch0));
  assign x1 = wm'(signed'(ch1));
  assign x2 = wm'(signed'(ch2));
  assign x3 = wm'(signed'(ch3));

  // Arithmetic shift of the sum floors toward -inf; the cast only drops
  // sign copies or adds them.
  assign s_ext = ws'(sum_r >>> 4);

  always_comb begin
    mixed_nxt = s_ext[wout-1:0];
`ifdef SND_MIX4_CLIP_EN
    clip_nxt  = 1'b0;
`endif
    if (s_ext > sat_hi) begin
      mixed_nxt = sat_hi[wout-1:0];
`ifdef SND_MIX4_CLIP_EN
      clip_nxt  = 1'b1;
`endif
    end else if (s_ext < sat_lo) begin
      mixed_nxt = sat_lo[wout-1:0];
`ifdef SND_MIX4_CLIP_EN
      clip_nxt  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_r  <= '0;
      p1_r  <= '0;
      p2_r  <= '0;
      p3_r  <= '0;
      sum_r <= '0;
      mixed <= '0;
`ifdef SND_MIX4_CLIP_EN
      clip  <= 1'b0;
`endif
    end else if (cen) begin
      // Gain is zero-extended to 9 bits so it stays non-negative as a
      // signed multiplicand.
      p0_r  <= wp'(x0) * wp'(signed'({1'b0, gain0}));
      p1_r  <= wp'(x1) * wp'(signed'({1'b0, gain1}));
      p2_r  <= wp'(x2) * wp'(signed'({1'b0, gain2}));
      p3_r  <= wp'(x3) * wp'(signed'({1'b0, gain3}));
      sum_r <= wsum'(p0_r) + wsum'(p1_r) + wsum'(p2_r) + wsum'(p3_r);
      mixed <= mixed_nxt;
`ifdef SND_MIX4_CLIP_EN
      clip  <= clip_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_snd_mix4.sv
module tb_snd_mix4;

  localparam int W0 = 16, W1 = 16, W2 = 10, W3 = 16, WOUT = 16;

  logic clk = 1'b0;
  logic rst, cen;
  logic [W0-1:0] ch0;
  logic [W1-1:0] ch1;
  logic [W2-1:0] ch2;
  logic [W3-1:0] ch3;
  logic [7:0] gain0, gain1, gain2, gain3;
  logic [WOUT-1:0] mixed;
`ifdef SND_MIX4_CLIP_EN
  logic clip;
`endif

  snd_mix4 #(.w0(W0), .w1(W1), .w2(W2), .w3(W3), .wout(WOUT)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .gain0(gain0), .gain1(gain1), .gain2(gain2), .gain3(gain3),
    .mixed(mixed)
`ifdef SND_MIX4_CLIP_EN
    , .clip(clip)
`endif
  );

  always #5 clk = ~clk;

  int cv[4];
  int gv[4];
  int n_cmp = 0;
  int n_err = 0;

  longint val_q[$];
  bit     clp_q[$];
  longint exp_mixed;
  bit     exp_clip;

  // Reference: integer mix, floor divide by 16, clamp to the output range.
  function automatic void calc(output longint v, output bit c);
    longint acc, hi, lo;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(cv[i]) * longint'(gv[i]);
    acc = acc >>> 4;
    hi = (longint'(1) <<< (WOUT - 1)) - 1;
    lo = -hi - 1;
    c = 1'b0;
    v = acc;
    if (acc > hi) begin v = hi; c = 1'b1; end
    else if (acc < lo) begin v = lo; c = 1'b1; end
  endfunction

  task automatic apply();
    ch0 = W0'(cv[0]); ch1 = W1'(cv[1]); ch2 = W2'(cv[2]); ch3 = W3'(cv[3]);
    gain0 = 8'(gv[0]); gain1 = 8'(gv[1]); gain2 = 8'(gv[2]); gain3 = 8'(gv[3]);
  endtask

  // One clock: drive, edge, advance the reference by one output slot per cen tick.
  task automatic step(input bit c, input bit r);
    longint v;
    bit cl;
    cen = c;
    rst = r;
    apply();
    @(posedge clk);
    if (r) begin
      val_q.delete(); clp_q.delete();
      val_q.push_back(0); val_q.push_back(0);
      clp_q.push_back(0); clp_q.push_back(0);
      exp_mixed = 0; exp_clip = 0;
    end else if (c) begin
      calc(v, cl);
      val_q.push_back(v); clp_q.push_back(cl);
      exp_mixed = val_q.pop_front();
      exp_clip  = clp_q.pop_front();
    end
    #1;
  endtask

  task automatic rand_inputs();
    cv[0] = int'($urandom_range(0, 65535)) - 32768;
    cv[1] = int'($urandom_range(0, 65535)) - 32768;
    cv[2] = int'($urandom_range(0, 1023)) - 512;
    cv[3] = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < 4; i++) gv[i] = int'($urandom_range(0, 255));
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 4; i++) begin cv[i] = 0; gv[i] = 0; end
  endtask

  task automatic test_reset();
    zero_inputs();
    cv[0] = 1234; gv[0] = 16;
    step(1'b0, 1'b1);
    n_cmp++;
    if (mixed !== 16'd0) begin
      n_err++; $display("FAIL reset_cen0: mixed=%0d expected 0", $signed(mixed));
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (mixed !== 16'd0) begin
      n_err++; $display("FAIL reset_cen1: mixed=%0d expected 0", $signed(mixed));
    end
`ifdef SND_MIX4_CLIP_EN
    n_cmp++;
    if (clip !== 1'b0) begin
      n_err++; $display("FAIL reset_clip: clip=%0b expected 0", clip);
    end
`endif
  endtask

  task automatic test_basic();
    logic [WOUT-1:0] want;
    zero_inputs();
    step(1'b1, 1'b1);
    cv[0] = 1000; gv[0] = 16;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      want = (i < 2) ? WOUT'(0) : WOUT'(1000);
      n_cmp++;
      if (mixed !== want) begin
        n_err++; $display("FAIL basic tick%0d: mixed=%0d expected %0d", i + 1, $signed(mixed), $signed(want));
      end
    end
  endtask

  // Directed single-result cases: reset, hold inputs for 3 ticks, check a constant.
  task automatic test_directed();
    int tc0[10] = '{20000, -20000, 32767, 32767, -32768, -32768, 1001, -1001, 0,   100};
    int tc1[10] = '{20000, -20000, 0,     1,     0,      -1,     0,    0,     0,   0};
    int tg0[10] = '{16,    16,     16,    16,    16,     16,     8,    8,     0,   32};
    int tc2[10] = '{0,     0,      0,     0,     0,      0,      0,    0,     -1,  -1};
    int tg2[10] = '{0,     0,      0,     0,     0,      0,      0,    0,     128, 128};
    int twant[10] = '{32767, -32768, 32767, 32767, -32768, -32768, 500, -501, -8, 192};
    bit tclip[10] = '{1,   1,      0,     1,     0,      1,      0,    0,     0,   0};
    for (int k = 0; k < 10; k++) begin
      zero_inputs();
      step(1'b1, 1'b1);
      cv[0] = tc0[k]; cv[1] = tc1[k]; gv[0] = tg0[k]; gv[1] = tg0[k];
      cv[2] = tc2[k]; gv[2] = tg2[k];
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      n_cmp++;
      if (mixed !== WOUT'(twant[k])) begin
        n_err++; $display("FAIL directed case%0d: mixed=%0d expected %0d", k, $signed(mixed), twant[k]);
      end
`ifdef SND_MIX4_CLIP_EN
      n_cmp++;
      if (clip !== tclip[k]) begin
        n_err++; $display("FAIL directed_clip case%0d: clip=%0b expected %0b", k, clip, tclip[k]);
      end
`else
      if (tclip[k] && k < 0) $display("unused");
`endif
    end
  endtask

  task automatic test_random();
    zero_inputs();
    step(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if (i % 7 == 0) gv[$urandom_range(0, 3)] = 255;
      step(1'b1, 1'b0);
      n_cmp++;
      if (mixed !== WOUT'(exp_mixed)) begin
        n_err++; $display("FAIL random tick%0d: mixed=%0d expected %0d", i, $signed(mixed), exp_mixed);
      end
`ifdef SND_MIX4_CLIP_EN
      n_cmp++;
      if (clip !== exp_clip) begin
        n_err++; $display("FAIL random_clip tick%0d: clip=%0b expected %0b", i, clip, exp_clip);
      end
`endif
    end
  endtask

  task automatic test_cen_gating();
    logic [WOUT-1:0] prev;
    zero_inputs();
    step(1'b1, 1'b1);
    prev = mixed;
    for (int i = 0; i < 240; i++) begin
      rand_inputs();
      step((i % 4) == 0, 1'b0);
      n_cmp++;
      if (mixed !== WOUT'(exp_mixed)) begin
        n_err++; $display("FAIL cen_gating clk%0d: mixed=%0d expected %0d", i, $signed(mixed), exp_mixed);
      end
      if ((i % 4) != 0) begin
        n_cmp++;
        if (mixed !== prev) begin
          n_err++; $display("FAIL cen_hold clk%0d: mixed=%0d expected held %0d", i, $signed(mixed), $signed(prev));
        end
      end
      prev = mixed;
    end
  endtask

  task automatic test_reset_mid();
    zero_inputs();
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      cv[0] = 1000 + int'($urandom_range(0, 5000)); gv[0] = 16;
      cv[1] = 0; cv[2] = 0; cv[3] = 0;
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (mixed !== 16'd0) begin
      n_err++; $display("FAIL reset_mid: mixed=%0d expected 0", $signed(mixed));
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (mixed !== 16'd0) begin
      n_err++; $display("FAIL reset_mid_idle: mixed=%0d expected 0", $signed(mixed));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (i < 2 && mixed !== 16'd0) begin
        n_err++; $display("FAIL reset_mid_flush tick%0d: mixed=%0d expected 0", i + 1, $signed(mixed));
      end else if (i == 2 && mixed !== WOUT'(cv[0])) begin
        n_err++; $display("FAIL reset_mid_first tick3: mixed=%0d expected %0d", $signed(mixed), cv[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b0;
    zero_inputs();
    apply();
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_cen_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
